// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage owning the PC and IF/ID register, with redirect, stall and self-jump halt
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] InstrMemAddress,
    input  logic [31:0] InstrMemData,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic [31:0] PCValue,
    output logic        Halted,
    output logic        Misaligned,
    output logic [15:0] StallCount,
    output logic [15:0] BubbleCount
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;
    logic [0:0]  state;
    logic [31:0] pc;
    logic        self_jump;
    assign self_jump       = RedirectTarget == IFID_PCPlus4 - 32'd4;
    assign InstrMemAddress = pc;
    assign PCValue         = pc;
    assign Halted          = state == HALT;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state            <= RUN;
            pc               <= RESET_PC;
            IFID_Instruction <= NOP;
            IFID_PCPlus4     <= 32'd0;
            Misaligned       <= 1'b0;
            StallCount       <= 16'd0;
            BubbleCount      <= 16'd0;
        end else if (state == HALT) begin
            IFID_Instruction <= NOP;
            IFID_PCPlus4     <= 32'd0;
        end else if (Redirect) begin
            // the sequential word fetched this cycle is squashed into a bubble
            pc               <= {RedirectTarget[31:2], 2'b00};
            IFID_Instruction <= NOP;
            IFID_PCPlus4     <= 32'd0;
            BubbleCount      <= &BubbleCount ? BubbleCount : BubbleCount + 16'd1;
            Misaligned       <= Misaligned | (|RedirectTarget[1:0]);
            state            <= self_jump ? HALT : RUN;
        end else if (Stall) begin
            StallCount <= &StallCount ? StallCount : StallCount + 16'd1;
        end else begin
            pc               <= pc + 32'd4;
            IFID_Instruction <= InstrMemData;
            IFID_PCPlus4     <= pc + 32'd4;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks plus a per-cycle reference model of the fetch stage
module tb_fetch_stage;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = 32'd0;
    logic [31:0] InstrMemAddress, InstrMemData, IFID_Instruction, IFID_PCPlus4, PCValue;
    logic        Halted, Misaligned;
    logic [15:0] StallCount, BubbleCount;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [31:0] m_pc, m_ins, m_p4;
    bit          m_halt, m_mis;
    int unsigned m_sc, m_bc;

    fetch_stage dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
        .InstrMemAddress(InstrMemAddress), .InstrMemData(InstrMemData),
        .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4), .PCValue(PCValue),
        .Halted(Halted), .Misaligned(Misaligned), .StallCount(StallCount), .BubbleCount(BubbleCount)
    );

    always #5 Clk = ~Clk;
    assign InstrMemData = 32'hA000_0000 | InstrMemAddress;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_ins = 32'd0; m_p4 = 32'd0;
        m_halt = 1'b0; m_mis = 1'b0; m_sc = 0; m_bc = 0;
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] p4);
        check({tag, ".pc"}, PCValue, pc);
        check({tag, ".ins"}, IFID_Instruction, ins);
        check({tag, ".p4"}, IFID_PCPlus4, p4);
    endtask

    // reference model: one fetch-stage step per rising edge, then compare shortly after
    always @(posedge Clk) begin
        if (!Rst) begin
            if (m_halt) begin
                m_ins = 32'd0; m_p4 = 32'd0;
            end else if (Redirect) begin
                m_halt = RedirectTarget == m_p4 - 32'd4;
                m_pc   = RedirectTarget & ~32'd3;
                m_ins  = 32'd0; m_p4 = 32'd0;
                m_bc   = (m_bc < 65535) ? m_bc + 1 : 65535;
                m_mis  = m_mis || (RedirectTarget % 4 != 0);
            end else if (Stall) begin
                m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
            end else begin
                m_ins = 32'hA000_0000 | m_pc;
                m_p4  = m_pc + 32'd4;
                m_pc  = m_pc + 32'd4;
            end
        end
        #1;
        if (chk_en) begin
            check("m.pc", PCValue, m_pc);
            check("m.addr", InstrMemAddress, m_pc);
            check("m.ins", IFID_Instruction, m_ins);
            check("m.p4", IFID_PCPlus4, m_p4);
            check("m.halt", {31'd0, Halted}, {31'd0, m_halt});
            check("m.mis", {31'd0, Misaligned}, {31'd0, m_mis});
            check("m.sc", {16'd0, StallCount}, m_sc);
            check("m.bc", {16'd0, BubbleCount}, m_bc);
        end
    end

    initial begin
        model_reset();
        #2;
        check_state("rst0", 32'd0, 32'd0, 32'd0);
        check("rst0.halt", {31'd0, Halted}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge Clk);
        check_state("seq", 32'h8, 32'hA000_0004, 32'h8);
        Stall = 1'b1;
        repeat (2) @(negedge Clk);
        Stall = 1'b0;
        check_state("stall", 32'h8, 32'hA000_0004, 32'h8);
        check("stall.sc", {16'd0, StallCount}, 32'd2);
        @(negedge Clk);
        check_state("unstall", 32'hC, 32'hA000_0008, 32'hC);
        Redirect = 1'b1; RedirectTarget = 32'h40;
        @(negedge Clk);
        Redirect = 1'b0;
        check_state("br", 32'h40, 32'd0, 32'd0);
        check("br.bc", {16'd0, BubbleCount}, 32'd1);
        @(negedge Clk);
        check_state("br.tgt", 32'h44, 32'hA000_0040, 32'h44);
        Stall = 1'b1; Redirect = 1'b1; RedirectTarget = 32'h42;
        @(negedge Clk);
        Stall = 1'b0; Redirect = 1'b0;
        check_state("prio", 32'h40, 32'd0, 32'd0);
        check("prio.sc", {16'd0, StallCount}, 32'd2);
        check("prio.bc", {16'd0, BubbleCount}, 32'd2);
        check("prio.mis", {31'd0, Misaligned}, 32'd1);
        repeat (5) @(negedge Clk);
        check_state("run", 32'h54, 32'hA000_0050, 32'h54);
        Redirect = 1'b1; RedirectTarget = 32'h50;
        @(negedge Clk);
        Redirect = 1'b0;
        check_state("halt", 32'h50, 32'd0, 32'd0);
        check("halt.flag", {31'd0, Halted}, 32'd1);
        check("halt.bc", {16'd0, BubbleCount}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            Stall = 1'($urandom_range(1)); Redirect = 1'($urandom_range(1));
            RedirectTarget = $urandom;
            @(negedge Clk);
        end
        Stall = 1'b0; Redirect = 1'b0;
        check_state("held", 32'h50, 32'd0, 32'd0);
        check("held.sc", {16'd0, StallCount}, 32'd2);
        check("held.bc", {16'd0, BubbleCount}, 32'd3);
        check("held.mis", {31'd0, Misaligned}, 32'd1);
        #2;
        Rst = 1'b1;
        model_reset();
        #1;
        check_state("arst", 32'd0, 32'd0, 32'd0);
        check("arst.halt", {31'd0, Halted}, 32'd0);
        check("arst.mis", {31'd0, Misaligned}, 32'd0);
        check("arst.cnt", {StallCount, BubbleCount}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check_state("resume", 32'h4, 32'hA000_0000, 32'h4);
        Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFF8;
        @(negedge Clk);
        Redirect = 1'b0;
        repeat (2) @(negedge Clk);
        check_state("wrap", 32'd0, 32'hFFFF_FFFC, 32'd0);
        check("wrap.halt", {31'd0, Halted}, 32'd0);
        @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
